// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: three-stage pipelined IEEE-754 single-precision multiplier.
// Numeric conventions follow the butterfly adder: denormals flush to zero,
// results truncate, zero is always +0, exponent 255 has no Inf/NaN meaning.
// One global enable stalls every stage whenever the output holds an
// unaccepted result.

module fp_mult_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] z
);

   // Stage valid bits
   logic v1_q, v2_q, v3_q;

   // Stage 1 state
   logic              s1_sign_q;
   logic              s1_zero_q;
   logic signed [9:0] s1_exp_q;
   logic [23:0]       s1_ma_q;
   logic [23:0]       s1_mb_q;

   // Stage 2 state
   logic              s2_sign_q;
   logic              s2_zero_q;
   logic signed [9:0] s2_exp_q;
   logic [47:0]       s2_prod_q;

   // Stage 3 (output) state
   logic [31:0]       z_q;

   logic              en_p;
   logic [7:0]        ea, eb;
   logic signed [9:0] exp_sum;
   logic [47:0]       prod;
   logic [22:0]       mant;
   logic signed [9:0] exp_norm;
   logic [31:0]       z_d;
   logic              prod_unused;

   // Only an unaccepted result at the output can stall the pipeline.
   assign en_p     = ~v3_q | out_ready;
   assign in_ready = en_p;

   assign ea      = a[30:23];
   assign eb      = b[30:23];
   // Biased sum stays within 10-bit signed range: -127 .. 383.
   assign exp_sum = signed'({2'b00, ea}) + signed'({2'b00, eb}) - 10'sd127;

   assign prod = 48'(s1_ma_q) * 48'(s1_mb_q);

   // Low product bits are discarded by truncation.
   assign prod_unused = ^s2_prod_q[22:0];

   // Normalize the product and pack the result with zero/underflow/overflow handling.
   always_comb begin
      mant     = '0;
      exp_norm = '0;
      z_d      = '0;
      if (s2_prod_q[47]) begin
         mant     = s2_prod_q[46:24];
         exp_norm = s2_exp_q + 10'sd1;
      end else begin
         mant     = s2_prod_q[45:23];
         exp_norm = s2_exp_q;
      end
      if (s2_zero_q) begin
         z_d = 32'h0000_0000;
      end else if (exp_norm <= 10'sd0) begin
         z_d = 32'h0000_0000;
      end else if (exp_norm >= 10'sd255) begin
         z_d = {s2_sign_q, 8'hFF, 23'b0};
      end else begin
         z_d = {s2_sign_q, exp_norm[7:0], mant};
      end
   end

   // Advance all stages together when enabled; hold everything otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         v3_q      <= 1'b0;
         s1_sign_q <= 1'b0;
         s1_zero_q <= 1'b0;
         s1_exp_q  <= '0;
         s1_ma_q   <= '0;
         s1_mb_q   <= '0;
         s2_sign_q <= 1'b0;
         s2_zero_q <= 1'b0;
         s2_exp_q  <= '0;
         s2_prod_q <= '0;
         z_q       <= '0;
      end else if (en_p) begin
         v1_q      <= in_valid;
         v2_q      <= v1_q;
         v3_q      <= v2_q;
         s1_sign_q <= a[31] ^ b[31];
         s1_zero_q <= (ea == 8'd0) | (eb == 8'd0);
         s1_exp_q  <= exp_sum;
         s1_ma_q   <= {1'b1, a[22:0]};
         s1_mb_q   <= {1'b1, b[22:0]};
         s2_sign_q <= s1_sign_q;
         s2_zero_q <= s1_zero_q;
         s2_exp_q  <= s1_exp_q;
         s2_prod_q <= prod;
         z_q       <= z_d;
      end
   end

   assign out_valid = v3_q;
   assign z         = z_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed vector table plus hand-written sequences for
// streaming, backpressure and mid-flight reset.

module tb_fp_mult_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] z;

   fp_mult_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] z;
      string       name;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   int checks = 0;
   int passed = 0;
   int cyc    = 0;

   logic [31:0] got[$];
   int          got_cyc[$];

   // Record every output transfer with the cycle it happened in.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && out_valid && out_ready) begin
         got.push_back(z);
         got_cyc.push_back(cyc);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   task automatic set_vec(input int i, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] vz, input string nm);
      vecs[i].a    = va;
      vecs[i].b    = vb;
      vecs[i].z    = vz;
      vecs[i].name = nm;
   endtask

   // One isolated operation; latency counts edges including the accept edge.
   task automatic run_single(input int i);
      int edges;
      check({vecs[i].name, "_in_ready"}, 32'(in_ready), 32'd1);
      a        = vecs[i].a;
      b        = vecs[i].b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      edges    = 1;
      while (!out_valid && edges < 10) begin
         @(negedge clk);
         edges++;
      end
      check({vecs[i].name, "_latency"}, 32'(edges), 32'd3);
      check({vecs[i].name, "_z"}, z, vecs[i].z);
      @(negedge clk);
   endtask

   initial begin
      int   wait_cnt;
      logic ready_ok;
      logic seen_valid;

      set_vec(0,  32'h3FC00000, 32'h40000000, 32'h40400000, "mul_1p5x2");
      set_vec(1,  32'h3FC00000, 32'h3FC00000, 32'h40100000, "norm_p47");
      set_vec(2,  32'hC0000000, 32'h40400000, 32'hC0C00000, "neg_sign");
      set_vec(3,  32'h40400000, 32'h40400000, 32'h41100000, "mul_3x3");
      set_vec(4,  32'h00000000, 32'h40400000, 32'h00000000, "zero_a");
      set_vec(5,  32'h80000000, 32'hC0000000, 32'h00000000, "neg_zero");
      set_vec(6,  32'h7F000000, 32'h7F000000, 32'h7F800000, "overflow");
      set_vec(7,  32'hFF000000, 32'h7F000000, 32'hFF800000, "neg_overflow");
      set_vec(8,  32'h00800000, 32'h00800000, 32'h00000000, "underflow");
      set_vec(9,  32'h00400000, 32'h40000000, 32'h00000000, "denormal");
      set_vec(10, 32'h3FC00001, 32'h3FC00001, 32'h40100001, "truncate");
      set_vec(11, 32'h7E800000, 32'h40000000, 32'h7F000000, "max_exp");
      set_vec(12, 32'h7F7FFFFF, 32'h3FFFFFFF, 32'h7F800000, "norm_overflow");
      set_vec(13, 32'h00800000, 32'h3F800000, 32'h00800000, "min_exp");
      set_vec(14, 32'h00800000, 32'h3F000000, 32'h00000000, "underflow_edge");
      set_vec(15, 32'h3FC00000, 32'hC0400000, 32'hC0900000, "neg_4p5");
      set_vec(16, 32'h7F800000, 32'h00800000, 32'h40800000, "exp255_plain");

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      repeat (2) @(negedge clk);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_z", z, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready", 32'(in_ready), 32'd1);

      // Isolated operations
      for (int i = 0; i < NV; i++) run_single(i);

      // Back-to-back stream with out_ready held high
      got.delete();
      got_cyc.delete();
      ready_ok = 1'b1;
      for (int i = 0; i < NV; i++) begin
         a        = vecs[i].a;
         b        = vecs[i].b;
         in_valid = 1'b1;
         if (!in_ready) ready_ok = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      wait_cnt = 0;
      while (got.size() < NV && wait_cnt < 10) begin
         if (!in_ready) ready_ok = 1'b0;
         @(negedge clk);
         wait_cnt++;
      end
      check("stream_in_ready", 32'(ready_ok), 32'd1);
      check("stream_count", 32'(got.size()), 32'(NV));
      if (got.size() == NV)
         check("stream_consecutive", 32'(got_cyc[NV-1] - got_cyc[0]), 32'(NV - 1));
      for (int i = 0; i < NV; i++)
         check({"stream_", vecs[i].name}, (i < got.size()) ? got[i] : 32'bx, vecs[i].z);

      // Backpressure: the 4th op is held by the source during a 5-cycle stall
      repeat (2) @(negedge clk);
      got.delete();
      got_cyc.delete();
      for (int i = 0; i < 3; i++) begin
         a        = vecs[i].a;
         b        = vecs[i].b;
         in_valid = 1'b1;
         @(negedge clk);
      end
      check("bp_out_valid_rise", 32'(out_valid), 32'd1);
      a         = vecs[3].a;
      b         = vecs[3].b;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_z", z, vecs[0].z);
         check("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_cnt = 0;
      while (got.size() < 4 && wait_cnt < 10) begin
         @(negedge clk);
         wait_cnt++;
      end
      repeat (4) @(negedge clk);
      check("bp_count", 32'(got.size()), 32'd4);
      for (int k = 0; k < 4; k++)
         check({"bp_order_", vecs[k].name}, (k < got.size()) ? got[k] : 32'bx, vecs[k].z);

      // Reset with three operations in flight
      got.delete();
      got_cyc.delete();
      a        = vecs[10].a;
      b        = vecs[10].b;
      in_valid = 1'b1;
      @(negedge clk);
      a = vecs[11].a;
      b = vecs[11].b;
      @(negedge clk);
      a = vecs[15].a;
      b = vecs[15].b;
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check("rst_mid_out_valid", 32'(out_valid), 32'd0);
      check("rst_mid_z", z, 32'h0);
      check("rst_mid_in_ready", 32'(in_ready), 32'd1);
      rst        = 1'b0;
      seen_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (out_valid) seen_valid = 1'b1;
      end
      check("rst_no_stale_valid", 32'(seen_valid), 32'd0);
      check("rst_no_stale_count", 32'(got.size()), 32'd0);

      // Pipeline still works after the mid-flight reset
      run_single(3);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Three-stage pipelined IEEE-754 single-precision multiplier for the FFT datapath. It forms the twiddle-factor products (x·w) and feeds them to the butterfly's combinational floating-point adder. Its numeric conventions match that adder: denormals flush to zero, results truncate, and zero is always +0. A valid/ready handshake with whole-pipeline stall lets the butterfly sequencer apply backpressure.

## Interface
- No parameters; the format is fixed at 32-bit single precision (1 sign / 8 exponent / 23 mantissa bits, bias 127).
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b present this cycle.
- in_ready  output  1  pipeline can accept; a transfer occurs when in_valid && in_ready.
- a  input  32  multiplicand (IEEE single).
- b  input  32  multiplier (IEEE single).
- out_valid  output  1  z holds a result.
- out_ready  input  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- z  output  32  product (IEEE single).

## Operation
- Unpack: exponent field 0 means the operand is zero (denormals flushed); otherwise mantissa = {1, frac[22:0]} (24 bits).
- Exponent fields 255 are treated as ordinary values; there is no Inf/NaN decoding.
- Stage 1 registers:
  - sign = a[31]^b[31]
  - zero flag = (a exp==0)|(b exp==0)
  - 10-bit signed e = ea+eb-127
  - both 24-bit mantissas
- Stage 2 registers the 48-bit product p = ma*mb, and passes sign, zero and e along.
- Stage 3 normalizes and packs:
  - If p[47]=1: mant = p[46:24], en = e+1.
  - Else: mant = p[45:23], en = e.
  - Truncate; no rounding and no sticky bits.
- Packing rules, in priority order:
  - zero flag → z = 32'h00000000 (sign forced 0).
  - en <= 0 (underflow) → z = 32'h00000000.
  - en >= 255 (overflow) → z = {sign, 8'hFF, 23'b0}.
  - otherwise → z = {sign, en[7:0], mant}.
- Each stage carries a valid bit: v1, v2, v3. out_valid = v3.
- Global enable: en_p = ~v3 | out_ready.
  - When en_p=1, all stages shift: v1 <= in_valid, v2 <= v1, v3 <= v2, and data moves with them.
  - When en_p=0, all stage registers (data and valid) hold.
- in_ready = en_p (combinational from v3 and out_ready).
- Bubbles are not collapsed; only the output stage gates the stall.
- Results leave in issue order; no reordering and no drops.
- Data registers of invalid stages may hold anything; z is don't-care while out_valid=0.

## Timing
- Reset: v1=v2=v3=0, out_valid=0, z=32'h0. With v3=0, in_ready=1 in the cycle after reset.
- Reset mid-operation discards all in-flight operands; nothing is emitted for them.
- rst has priority over transfers in the same cycle.
- Latency: an operand accepted at edge N (in_valid && in_ready) gives out_valid=1 with its z after edge N+3, assuming no stall.
- Stall cycles add one cycle each to latency.
- Throughput is one result per cycle with out_ready held high.
- Output stability: while out_valid=1 and out_ready=0, z and out_valid hold and in_ready=0.
- An input presented while in_ready=0 is not captured. The source must hold it (valid/ready rule: the source does not drop in_valid or change a/b until accepted).
- Simultaneous accept and emit in one cycle (v3=1, out_ready=1, in_valid=1) is legal and loses nothing.

## Test plan
- Basic: a=3FC00000 (1.5), b=40000000 (2.0), out_ready=1 → out_valid exactly 3 edges after accept, z=40400000 (3.0). Also 1.5·1.5 → 40100000 (p[47] normalization path).
- Sign and zero: C0000000·40400000 → C0C00000. Then 00000000·40400000 → 00000000. Then 80000000·C0000000 → 00000000 (+0).
- Range limits:
  - 7F000000·7F000000 → 7F800000.
  - FF000000·7F000000 → FF800000.
  - 00800000·00800000 → 00000000 (underflow).
  - 00400000 (denormal)·40000000 → 00000000.
- Streaming: 8 back-to-back operand pairs with out_ready=1 → 8 consecutive out_valid cycles, correct values in order, in_ready constantly 1.
- Backpressure:
  - Issue 4 ops, then drop out_ready for 5 cycles once v3=1.
  - Required: z held stable, in_ready=0, the 4th op not lost.
  - After out_ready rises, all 4 results emerge in order with no duplicates.
- Reset mid-flight: assert rst with 3 ops in flight → next cycle out_valid=0, z=0, in_ready=1. No stale result appears in the following 5 cycles.
